ddr_template_reader_256: RTL and testbench
==========================================

// Module: ddr_template_reader_256
// PURPOSE
//  Read-back counterpart of the DDR template setup writer. It fetches packet-template
//  words from DDR through the avalon_mm_ddr request interface (rd_rq/rd_adr/rd_valid/rd_data).
//  It unpacks each 256-bit line into eight 32-bit words, low word (bits[31:0]) first,
//  matching the writer's packing, and streams them to the packet TX path with valid/ready.
// PARAMETERS
//  ADDR_W       25    DDR line address width
//  CNT_W        16    width of word count
//  TIMEOUT_CYC  1023  max cycles in WAIT before abort with error
// PORTS
//  clk         in   1       system clock (clk_125_tx_rx domain)
//  rst_n       in   1       async active-low reset
//  start       in   1       1-cycle pulse: begin read job (ignored while busy)
//  start_addr  in   ADDR_W  first DDR line address, sampled on start
//  num_words   in   CNT_W   32-bit words to deliver, sampled on start
//  busy        out  1       high from cycle after accepted start until done pulse
//  done        out  1       1-cycle pulse at job end (normal or aborted)
//  error       out  1       sticky timeout flag, cleared on next accepted start
//  rd_rq       out  1       read request to avalon_mm_ddr
//  rd_adr      out  ADDR_W  line address, stable while rd_rq high
//  rd_valid    in   1       read data valid
//  rd_data     in   256     read line
//  word_data   out  32      output word
//  word_valid  out  1       word_data valid
//  word_ready  in   1       sink accepts word when word_valid & word_ready
//  word_last   out  1       high with final word of job
// BEHAVIOUR
//  Reset: busy=done=error=rd_rq=word_valid=word_last=0, rd_adr=0, word_data=0, FSM=IDLE.
//   Reset mid-job aborts immediately. No done pulse is issued. The sink sees word_valid drop.
//  lines = (num_words+7)>>3 (CNT_W+1-bit math, no overflow).
//   Last line emits num_words[2:0] words, or 8 when num_words[2:0]==0.
//  FSM IDLE->REQ->WAIT->DRAIN->(REQ|DONE)->IDLE:
//   IDLE : start -> latch addr/count, error<=0, busy<=1.
//          num_words==0 -> DONE directly, with no reads.
//   REQ  : rd_rq=1 with rd_adr=current line. Next cycle -> WAIT (rd_rq held high).
//   WAIT : rd_rq stays high until rd_valid. On rd_valid: capture rd_data, rd_rq<=0, ->DRAIN.
//          Timeout counter reaches TIMEOUT_CYC -> rd_rq<=0, error<=1, ->DONE.
//   DRAIN: word_valid=1, word_data=line[32*idx+:32], idx 0..7.
//          Advance idx only on word_valid&word_ready. word_data stays stable under backpressure.
//          Last word of line: if more lines -> rd_adr+1 (wraps modulo 2^ADDR_W), ->REQ.
//          Otherwise ->DONE.
//   DONE : done=1 for one cycle, busy<=0, ->IDLE.
//  word_last=1 only on the final word of the job.
//  Latency: start at cycle 0 -> rd_rq high at cycle 2. rd_valid at n -> word_valid at n+1.
//  rd_valid outside WAIT is ignored. Only one read is outstanding at any time.
//  start while busy is ignored, including in the DONE cycle.
// TESTING
//  start_addr=0, num_words=8, rd_valid 3 cycles after rd_rq
//   -> one read at addr 0; 8 words low-first; word_last on 8th word; done pulse once.
//  num_words=28 from template image (word0=0, word1=0x40, word2=0x14CC...)
//   -> reads at addr 0..3; 28 words equal to the image; last line delivers 4 words.
//  word_ready toggled 1/0 every cycle
//   -> no dropped or duplicated word; word_data stable while valid & !ready.
//  start_addr=25'h1FFFFFF, num_words=16
//   -> reads at 1FFFFFF then 0000000.
//  rd_valid never asserted
//   -> rd_rq drops after TIMEOUT_CYC cycles; error=1; done pulse.
//   -> a new start clears error.
//  num_words=0 -> no rd_rq; done pulse 2 cycles after start.
//  rst_n low mid-DRAIN -> all outputs 0 asynchronously; next start runs cleanly.

Source files
------------

// File: rtl/ddr_template_reader_256_if.sv
// Bundle of the job-control, DDR read-request and word-stream signals of the
// DDR template reader. The master side is the job controller / DDR model / word sink;
// the slave side is the reader itself.
interface ddr_template_reader_256_if #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned CNT_W  = 16
) ();
    // Job control
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  num_words;
    logic              busy;
    logic              done;
    logic              error;

    // DDR read request channel
    logic              rd_rq;
    logic [ADDR_W-1:0] rd_adr;
    logic              rd_valid;
    logic [255:0]      rd_data;

    // Word stream towards the packet TX path
    logic [31:0]       word_data;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;

    modport master (
        output start, start_addr, num_words, rd_valid, rd_data, word_ready,
        input  busy, done, error, rd_rq, rd_adr, word_data, word_valid, word_last
    );

    modport slave (
        input  start, start_addr, num_words, rd_valid, rd_data, word_ready,
        output busy, done, error, rd_rq, rd_adr, word_data, word_valid, word_last
    );
endinterface

// File: rtl/ddr_template_reader_256.sv
// DDR template reader: fetches 256-bit template lines from DDR one at a time and
// streams them out as 32-bit words, low word first, with valid/ready handshake.
// A read that is not answered within TIMEOUT_CYC cycles aborts the job with a sticky
// error flag. All outputs are registered.
module ddr_template_reader_256 #(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input logic                      clk,
    input logic                      rst_n,
    ddr_template_reader_256_if.slave bus
);
    localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYC + 1);
    // Counter value of the last cycle rd_rq may stay high while waiting
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDrain,
        StDone
    } state_e;

    state_e            state;
    logic [7:0][31:0]  line;        // captured DDR line, word k in line[k]
    logic [2:0]        idx;         // index of the word currently presented
    logic [2:0]        last_idx;    // index of the final word within the final line
    logic [CNT_W:0]    lines_left;  // lines still to drain, including the current one
    logic [TMO_W-1:0]  tmo_cnt;

    logic              busy;
    logic              done;
    logic              error;
    logic              rd_rq;
    logic [ADDR_W-1:0] rd_adr;
    logic [31:0]       word_data;
    logic              word_valid;
    logic              word_last;

    logic [CNT_W:0]    lines_total;
    logic              final_line;
    logic [2:0]        line_end;

    // Job geometry: line count from the requested word count, and the word index that
    // closes the current line (short only for the final line of the job).
    always_comb begin
        lines_total = ({1'b0, bus.num_words} + (CNT_W + 1)'(7)) >> 3;
        final_line  = (lines_left == (CNT_W + 1)'(1));
        line_end    = final_line ? last_idx : 3'd7;
    end

    // Main control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            line       <= '0;
            idx        <= '0;
            last_idx   <= '0;
            lines_left <= '0;
            tmo_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            rd_rq      <= 1'b0;
            rd_adr     <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        rd_adr     <= bus.start_addr;
                        lines_left <= lines_total;
                        // A multiple of eight words fills the final line (index 7)
                        last_idx   <= bus.num_words[2:0] - 3'd1;
                        state      <= (bus.num_words == '0) ? StDone : StReq;
                    end
                end

                StReq: begin
                    rd_rq   <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= StWait;
                end

                StWait: begin
                    if (bus.rd_valid) begin
                        line       <= bus.rd_data;
                        rd_rq      <= 1'b0;
                        idx        <= 3'd0;
                        word_valid <= 1'b1;
                        word_data  <= bus.rd_data[31:0];
                        word_last  <= final_line && (line_end == 3'd0);
                        state      <= StDrain;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rd_rq <= 1'b0;
                        error <= 1'b1;
                        state <= StDone;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                StDrain: begin
                    if (bus.word_ready) begin
                        if (idx == line_end) begin
                            word_valid <= 1'b0;
                            word_last  <= 1'b0;
                            lines_left <= lines_left - (CNT_W + 1)'(1);
                            if (final_line) begin
                                state <= StDone;
                            end else begin
                                rd_adr <= rd_adr + ADDR_W'(1);
                                state  <= StReq;
                            end
                        end else begin
                            idx       <= idx + 3'd1;
                            word_data <= line[idx + 3'd1];
                            word_last <= final_line && ((idx + 3'd1) == line_end);
                        end
                    end
                end

                StDone: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error;
    assign bus.rd_rq      = rd_rq;
    assign bus.rd_adr     = rd_adr;
    assign bus.word_data  = word_data;
    assign bus.word_valid = word_valid;
    assign bus.word_last  = word_last;
endmodule

// File: tb/tb_ddr_template_reader_256.sv
// Directed bench for the DDR template reader: a DDR responder model, a word sink with
// selectable backpressure, and one task per scenario.
module tb_ddr_template_reader_256;
    logic clk;
    logic rst_n;

    ddr_template_reader_256_if #(.ADDR_W(25), .CNT_W(16)) bus ();

    ddr_template_reader_256 #(
        .ADDR_W     (25),
        .CNT_W      (16),
        .TIMEOUT_CYC(1023)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Environment controls
    bit rsp_en     = 1'b1;
    int rsp_delay  = 3;
    bit use_img    = 1'b0;
    int ready_mode = 0;     // 0: always ready, 1: toggle, 2: never ready

    logic [31:0] img [0:31];

    // Observations
    logic [31:0] got_data[$];
    bit          got_last[$];
    logic [24:0] rd_log[$];
    int          done_cnt  = 0;
    int          rq_cycles = 0;
    int          stab_viol = 0;

    function automatic logic [31:0] pat(input logic [24:0] a, input logic [2:0] i);
        return {3'b101, a, 1'b0, i};
    endfunction

    function automatic logic [255:0] line_of(input logic [24:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            if (use_img && a < 25'd4) l[32*i +: 32] = img[a*8 + i];
            else                      l[32*i +: 32] = pat(a, 3'(i));
        end
        return l;
    endfunction

    // DDR responder: answers each request after rsp_delay cycles
    initial begin : ddr_model
        logic [24:0] a;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.rd_rq && rsp_en && rst_n) begin
                a = bus.rd_adr;
                rd_log.push_back(a);
                repeat (rsp_delay - 1) @(negedge clk);
                bus.rd_valid = 1'b1;
                bus.rd_data  = line_of(a);
                @(negedge clk);
                bus.rd_valid = 1'b0;
                bus.rd_data  = '0;
            end
        end
    end

    // Word sink and event counters
    initial begin : sink
        bit          r;
        bit          hold_seen;
        logic [31:0] hold_data;
        hold_seen      = 1'b0;
        hold_data      = '0;
        bus.word_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.done)  done_cnt++;
            if (bus.rd_rq) rq_cycles++;
            if (hold_seen && rst_n && !(bus.word_valid && bus.word_data == hold_data))
                stab_viol++;
            case (ready_mode)
                1:       r = ~bus.word_ready;
                2:       r = 1'b0;
                default: r = 1'b1;
            endcase
            bus.word_ready = r;
            if (bus.word_valid && r) begin
                got_data.push_back(bus.word_data);
                got_last.push_back(bus.word_last);
            end
            hold_seen = bus.word_valid && !r;
            hold_data = bus.word_data;
        end
    end

    task automatic clear_logs();
        got_data.delete();
        got_last.delete();
        rd_log.delete();
        done_cnt  = 0;
        rq_cycles = 0;
        stab_viol = 0;
    endtask

    // Pulse start for one cycle; returns at the falling edge of the cycle after start
    task automatic start_job(input logic [24:0] addr, input logic [15:0] n);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.num_words  = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s done_wait: got no done pulse in %0d cycles, required 1", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.error, bus.rd_rq, bus.word_valid, bus.word_last} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {bus.busy, bus.done, bus.error, bus.rd_rq, bus.word_valid, bus.word_last});
        end
        checks++;
        if (bus.rd_adr !== 25'd0 || bus.word_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got rd_adr=%h word_data=%h, required 0/0",
                     bus.rd_adr, bus.word_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_line();
        clear_logs();
        ready_mode = 0;
        rsp_delay  = 3;
        start_job(25'd0, 16'd8);
        checks++;
        if (bus.busy !== 1'b1 || bus.rd_rq !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle1: got busy=%b rd_rq=%b, required 1/0", bus.busy, bus.rd_rq);
        end
        @(negedge clk);
        checks++;
        if (bus.rd_rq !== 1'b1 || bus.rd_adr !== 25'd0) begin
            errors++;
            $display("FAIL single_cycle2: got rd_rq=%b rd_adr=%h, required 1/0",
                     bus.rd_rq, bus.rd_adr);
        end
        wait_done(100, "single");
        checks++;
        if (rd_log.size() != 1 || done_cnt != 1 || got_data.size() != 8) begin
            errors++;
            $display("FAIL single_counts: got reads=%0d dones=%0d words=%0d, required 1/1/8",
                     rd_log.size(), done_cnt, got_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_data[i] !== pat(25'd0, 3'(i)) || got_last[i] !== (i == 7)) begin
                    errors++;
                    $display("FAIL single_word%0d: got %h last=%b, required %h last=%b",
                             i, got_data[i], got_last[i], pat(25'd0, 3'(i)), i == 7);
                end
            end
        end
        checks++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got error=%b busy=%b, required 0/0", bus.error, bus.busy);
        end
    endtask

    task automatic test_template_image();
        clear_logs();
        for (int k = 0; k < 32; k++) img[k] = 32'h1000_0000 + 32'(k) * 32'h111;
        img[0] = 32'h0000_0000;
        img[1] = 32'h0000_0040;
        img[2] = 32'h0000_14CC;
        use_img    = 1'b1;
        ready_mode = 0;
        rsp_delay  = 2;
        start_job(25'd0, 16'd28);
        wait_done(300, "image");
        checks++;
        if (rd_log.size() != 4 || got_data.size() != 28) begin
            errors++;
            $display("FAIL image_counts: got reads=%0d words=%0d, required 4/28",
                     rd_log.size(), got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_log[i] !== 25'(i)) begin
                    errors++;
                    $display("FAIL image_addr%0d: got %h, required %h", i, rd_log[i], i);
                end
            end
            for (int i = 0; i < 28; i++) begin
                checks++;
                if (got_data[i] !== img[i] || got_last[i] !== (i == 27)) begin
                    errors++;
                    $display("FAIL image_word%0d: got %h last=%b, required %h last=%b",
                             i, got_data[i], got_last[i], img[i], i == 27);
                end
            end
        end
        use_img = 1'b0;
    endtask

    task automatic test_backpressure();
        clear_logs();
        ready_mode = 1;
        rsp_delay  = 1;
        start_job(25'h10, 16'd12);
        wait_done(300, "bp");
        ready_mode = 0;
        checks++;
        if (got_data.size() != 12 || stab_viol != 0) begin
            errors++;
            $display("FAIL bp_counts: got words=%0d unstable=%0d, required 12/0",
                     got_data.size(), stab_viol);
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (got_data[i] !== pat(25'(32'h10 + i / 8), 3'(i % 8)) ||
                    got_last[i] !== (i == 11)) begin
                    errors++;
                    $display("FAIL bp_word%0d: got %h last=%b, required %h last=%b", i,
                             got_data[i], got_last[i], pat(25'(32'h10 + i / 8), 3'(i % 8)),
                             i == 11);
                end
            end
        end
    endtask

    task automatic test_addr_wrap();
        clear_logs();
        rsp_delay = 3;
        start_job(25'h1FF_FFFF, 16'd16);
        wait_done(200, "wrap");
        checks++;
        if (rd_log.size() != 2 || got_data.size() != 16) begin
            errors++;
            $display("FAIL wrap_counts: got reads=%0d words=%0d, required 2/16",
                     rd_log.size(), got_data.size());
        end else begin
            checks++;
            if (rd_log[0] !== 25'h1FF_FFFF || rd_log[1] !== 25'h0) begin
                errors++;
                $display("FAIL wrap_addrs: got %h,%h, required 1ffffff,0000000",
                         rd_log[0], rd_log[1]);
            end
            checks++;
            if (got_data[7] !== pat(25'h1FF_FFFF, 3'd7) || got_data[8] !== pat(25'h0, 3'd0)) begin
                errors++;
                $display("FAIL wrap_data: got %h,%h, required %h,%h", got_data[7], got_data[8],
                         pat(25'h1FF_FFFF, 3'd7), pat(25'h0, 3'd0));
            end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        rsp_en = 1'b0;
        start_job(25'd5, 16'd8);
        repeat (10) @(negedge clk);
        // A start while busy must be ignored
        bus.start      = 1'b1;
        bus.start_addr = 25'd7;
        bus.num_words  = 16'd8;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rd_adr !== 25'd5 || bus.rd_rq !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got rd_adr=%h rd_rq=%b, required 5/1", bus.rd_adr, bus.rd_rq);
        end
        wait_done(1200, "timeout");
        checks++;
        if (rq_cycles != 1023 || bus.error !== 1'b1 || done_cnt != 1 || got_data.size() != 0) begin
            errors++;
            $display("FAIL timeout: got rq_cycles=%0d error=%b dones=%0d words=%0d, required 1023/1/1/0",
                     rq_cycles, bus.error, done_cnt, got_data.size());
        end
        rsp_en = 1'b1;
        clear_logs();
        start_job(25'd9, 16'd8);
        checks++;
        if (bus.error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: got error=%b, required 0", bus.error);
        end
        wait_done(100, "after_timeout");
        checks++;
        if (got_data.size() != 8 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout: got words=%0d error=%b, required 8/0",
                     got_data.size(), bus.error);
        end
    endtask

    task automatic test_zero_words();
        clear_logs();
        start_job(25'd3, 16'd0);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.rd_rq !== 1'b0) begin
            errors++;
            $display("FAIL zero_cycle1: got done=%b busy=%b rd_rq=%b, required 0/1/0",
                     bus.done, bus.busy, bus.rd_rq);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_cycle2: got done=%b busy=%b, required 1/0", bus.done, bus.busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rd_log.size() != 0 || got_data.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_counts: got reads=%0d words=%0d dones=%0d, required 0/0/1",
                     rd_log.size(), got_data.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid_drain();
        int k;
        clear_logs();
        ready_mode = 2;
        start_job(25'h20, 16'd16);
        k = 0;
        while (!bus.word_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!bus.word_valid) begin
            errors++;
            $display("FAIL rst_drain_reach: got word_valid=0, required 1");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.error, bus.rd_rq, bus.word_valid, bus.word_last} !== 6'b0) begin
            errors++;
            $display("FAIL rst_async_flags: got %b, required 000000",
                     {bus.busy, bus.done, bus.error, bus.rd_rq, bus.word_valid, bus.word_last});
        end
        checks++;
        if (bus.word_data !== 32'd0 || bus.rd_adr !== 25'd0) begin
            errors++;
            $display("FAIL rst_async_data: got word_data=%h rd_adr=%h, required 0/0",
                     bus.word_data, bus.rd_adr);
        end
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL rst_no_done: got dones=%0d, required 0", done_cnt);
        end
        clear_logs();
        start_job(25'h30, 16'd8);
        wait_done(100, "post_reset");
        checks++;
        if (got_data.size() != 8 || rd_log.size() != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL post_reset_counts: got words=%0d reads=%0d dones=%0d, required 8/1/1",
                     got_data.size(), rd_log.size(), done_cnt);
        end else begin
            checks++;
            if (got_data[0] !== pat(25'h30, 3'd0) || got_data[7] !== pat(25'h30, 3'd7) ||
                got_last[7] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_data: got %h,%h last=%b, required %h,%h last=1",
                         got_data[0], got_data[7], got_last[7], pat(25'h30, 3'd0),
                         pat(25'h30, 3'd7));
            end
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.num_words  = '0;
        for (int k = 0; k < 32; k++) img[k] = '0;
        test_reset();
        test_single_line();
        test_template_image();
        test_backpressure();
        test_addr_wrap();
        test_timeout();
        test_zero_words();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
